frame_capture: RTL and testbench

Sink side of the bolometer scan interface. Consumes the pixel stream produced while the scan counter walks the array, using the counter's line toggle (CHANGE) and frame strobe (RESET_BOLOMETER) to rebuild pixel position. Writes each pixel into a double-buffered frame memory and hands completed frames to the microcontroller with a ready/ack handshake. Line-length, frame-length and overrun faults are flagged.

---
 rtl/frame_capture.sv | 187 ++++++++++++++++++
 tb/tb_frame_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// Bolometer scan sink: rebuilds pixel position from line/frame strobes, writes double-buffered frame memory.
// Latency: one cycle from sampled pixel to registered memory write; handoff and error flags update on the causing edge.
// Backpressure: none on the pixel stream; a completed frame is dropped (overrun) while the MCU still holds the previous one.
module frame_capture #(
    parameter int HOR_PIX  = 384,
    parameter int VERT_PIX = 288,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 17
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] PIX_DATA,
    input  logic              PIX_VALID,
    input  logic              CHANGE,
    input  logic              FRAME_START,
    input  logic              FRAME_ACK,
    input  logic              ERR_CLR,
    output logic              MEM_WE,
    output logic [ADDR_W:0]   MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              READ_BANK,
    output logic              FRAME_READY,
    output logic              ERR_LINE,
    output logic              ERR_FRAME,
    output logic              ERR_OVERRUN
);
    localparam int COL_W = $clog2(HOR_PIX + 1);
    localparam int ROW_W = $clog2(VERT_PIX + 2);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              change_q;
    logic              start_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] lin;
    logic              wbank;

    // decoded FSM controls
    logic cap;
    logic arm_hit;
    logic hold_zero;

    logic              line_end;
    logic              frame_end;
    logic              pix_ok;
    logic              pix_drop;
    logic [COL_W-1:0]  col_fin;
    logic [ROW_W-1:0]  row_inc;
    logic [ROW_W-1:0]  row_fin;
    logic              line_bad;
    logic              frame_good;
    logic              frame_bad;
    logic              ready_kept;
    logic              clr_cnt;

    assign line_end   = CHANGE != change_q;
    assign frame_end  = FRAME_START & ~start_q;
    assign pix_ok     = cap & PIX_VALID & (col < COL_W'(HOR_PIX)) & (row < ROW_W'(VERT_PIX));
    assign pix_drop   = cap & PIX_VALID & ~pix_ok;
    assign col_fin    = col + COL_W'(pix_ok);
    // row saturates one past a full frame so a runaway line count stays distinguishable
    assign row_inc    = (row == ROW_W'(VERT_PIX + 1)) ? row : row + ROW_W'(1);
    assign row_fin    = line_end ? row_inc : row;
    assign line_bad   = cap & line_end & (col_fin != COL_W'(HOR_PIX));
    assign frame_good = cap & frame_end & (row_fin == ROW_W'(VERT_PIX));
    assign frame_bad  = cap & frame_end & ~frame_good;
    assign ready_kept = FRAME_READY & ~FRAME_ACK;
    assign clr_cnt    = hold_zero | arm_hit | (cap & frame_end);

    // state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ENABLE) state_nxt = ARMED;
            ARMED:   if (!ENABLE) state_nxt = IDLE;
                     else if (frame_end) state_nxt = CAPTURE;
            CAPTURE: if (!ENABLE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output decode: capture is suppressed in the cycle ENABLE drops so the partial frame is abandoned cleanly
    always_comb begin
        cap       = 1'b0;
        arm_hit   = 1'b0;
        hold_zero = 1'b0;
        case (state)
            IDLE:    hold_zero = 1'b1;
            ARMED: begin
                hold_zero = ~ENABLE;
                arm_hit   = ENABLE & frame_end;
            end
            CAPTURE: begin
                cap       = ENABLE;
                hold_zero = ~ENABLE;
            end
            default: hold_zero = 1'b1;
        endcase
    end

    // strobe history for edge detection, tracked in every state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            change_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            change_q <= CHANGE;
            start_q  <= FRAME_START;
        end
    end

    // position counters; lin realigns to the next line start instead of multiplying row*HOR_PIX
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
            lin <= '0;
        end else if (clr_cnt) begin
            col <= '0;
            row <= '0;
            lin <= '0;
        end else if (cap) begin
            if (line_end) begin
                col <= '0;
                row <= row_inc;
                lin <= lin + ADDR_W'(HOR_PIX) - ADDR_W'(col);
            end else if (pix_ok) begin
                col <= col + COL_W'(1);
                lin <= lin + ADDR_W'(1);
            end
        end
    end

    // registered memory write port; address/data hold between writes
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DATA <= '0;
        end else begin
            MEM_WE <= pix_ok;
            if (pix_ok) begin
                MEM_ADDR <= {wbank, lin};
                MEM_DATA <= PIX_DATA;
            end
        end
    end

    // bank swap and MCU handshake; an ack in the same cycle frees the read bank before the new frame is offered
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wbank       <= 1'b0;
            READ_BANK   <= 1'b0;
            FRAME_READY <= 1'b0;
        end else if (frame_good && !ready_kept) begin
            READ_BANK   <= wbank;
            wbank       <= ~wbank;
            FRAME_READY <= 1'b1;
        end else begin
            FRAME_READY <= ready_kept;
        end
    end

    // sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ERR_LINE    <= 1'b0;
            ERR_FRAME   <= 1'b0;
            ERR_OVERRUN <= 1'b0;
        end else begin
            ERR_LINE    <= (ERR_LINE & ~ERR_CLR) | pix_drop | line_bad;
            ERR_FRAME   <= (ERR_FRAME & ~ERR_CLR) | frame_bad;
            ERR_OVERRUN <= (ERR_OVERRUN & ~ERR_CLR) | (frame_good & ready_kept);
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a 4x3 array: writes, bank handoff, error flags, reset and enable drop.
module tb_frame_capture;
    localparam int HP = 4;
    localparam int VP = 3;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          CLK;
    logic          RESET;
    logic          ENABLE;
    logic [DW-1:0] PIX_DATA;
    logic          PIX_VALID;
    logic          CHANGE;
    logic          FRAME_START;
    logic          FRAME_ACK;
    logic          ERR_CLR;
    logic          MEM_WE;
    logic [AW:0]   MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic          READ_BANK;
    logic          FRAME_READY;
    logic          ERR_LINE;
    logic          ERR_FRAME;
    logic          ERR_OVERRUN;

    int   checks   = 0;
    int   failures = 0;
    logic chg      = 1'b0;

    frame_capture #(.HOR_PIX(HP), .VERT_PIX(VP), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .CHANGE(CHANGE), .FRAME_START(FRAME_START), .FRAME_ACK(FRAME_ACK), .ERR_CLR(ERR_CLR),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .READ_BANK(READ_BANK),
        .FRAME_READY(FRAME_READY), .ERR_LINE(ERR_LINE), .ERR_FRAME(ERR_FRAME), .ERR_OVERRUN(ERR_OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, then sample just after the edge
    task automatic step(input bit v, input logic [DW-1:0] d, input bit tog, input bit fs, input bit ack, input bit clr);
        PIX_VALID   = v;
        PIX_DATA    = d;
        if (tog) chg = ~chg;
        CHANGE      = chg;
        FRAME_START = fs;
        FRAME_ACK   = ack;
        ERR_CLR     = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // pixel expected to be written at {bank, idx}
    task automatic pix_w(input bit bank, input logic [7:0] tag, input int idx, input bit tog, input bit fs, input bit ack);
        logic [7:0]  i8;
        logic [AW:0] ea;
        i8 = 8'(idx);
        ea = {bank, AW'(idx)};
        step(1'b1, {tag, i8}, tog, fs, ack, 1'b0);
        chk("we", 32'(MEM_WE), 32'd1);
        chk("addr", 32'(MEM_ADDR), 32'(ea));
        chk("data", 32'(MEM_DATA), 32'({tag, i8}));
    endtask

    // pixel expected to be ignored
    task automatic pix_n(input bit tog);
        step(1'b1, 16'hdead, tog, 1'b0, 1'b0, 1'b0);
        chk("no_we", 32'(MEM_WE), 32'd0);
    endtask

    // full 4x3 frame; CHANGE toggles on each 4th pixel, FRAME_START rises with the last one
    task automatic run_frame(input bit bank, input logic [7:0] tag, input bit ack_last);
        for (int l = 0; l < VP; l++) begin
            for (int p = 0; p < HP; p++) begin
                pix_w(bank, tag, l*HP + p, p == HP-1, (l == VP-1) && (p == HP-1),
                      ack_last && (l == VP-1) && (p == HP-1));
            end
        end
    endtask

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; PIX_DATA = '0; PIX_VALID = 1'b0; CHANGE = 1'b0;
        FRAME_START = 1'b0; FRAME_ACK = 1'b0; ERR_CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we", 32'(MEM_WE), 32'd0);
        chk("rst_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_data", 32'(MEM_DATA), 32'd0);
        chk("rst_rbank", 32'(READ_BANK), 32'd0);
        chk("rst_ready", 32'(FRAME_READY), 32'd0);
        chk("rst_errs", 32'({ERR_LINE, ERR_FRAME, ERR_OVERRUN}), 32'd0);
        RESET = 1'b0;
        idle();

        // arm, then pixels before the frame strobe are ignored
        ENABLE = 1'b1;
        idle();
        pix_n(1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // frame 1 -> bank 0
        run_frame(1'b0, 8'h01, 1'b0);
        chk("f1_ready", 32'(FRAME_READY), 32'd1);
        chk("f1_rbank", 32'(READ_BANK), 32'd0);
        chk("f1_errs", 32'({ERR_LINE, ERR_FRAME, ERR_OVERRUN}), 32'd0);
        idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ack_ready", 32'(FRAME_READY), 32'd0);

        // frame 2 -> bank 1
        run_frame(1'b1, 8'h02, 1'b0);
        chk("f2_ready", 32'(FRAME_READY), 32'd1);
        chk("f2_rbank", 32'(READ_BANK), 32'd1);
        chk("f2_ovr", 32'(ERR_OVERRUN), 32'd0);

        // frame 3 without ack -> overrun, read bank held
        run_frame(1'b0, 8'h03, 1'b0);
        chk("f3_ovr", 32'(ERR_OVERRUN), 32'd1);
        chk("f3_rbank", 32'(READ_BANK), 32'd1);
        chk("f3_ready", 32'(FRAME_READY), 32'd1);

        // frame 4 overwrites bank 0
        run_frame(1'b0, 8'h04, 1'b0);
        chk("f4_rbank", 32'(READ_BANK), 32'd1);

        // short line: 3 pixels then CHANGE
        pix_w(1'b0, 8'h05, 0, 1'b0, 1'b0, 1'b0);
        pix_w(1'b0, 8'h05, 1, 1'b0, 1'b0, 1'b0);
        chk("short_pre", 32'(ERR_LINE), 32'd0);
        pix_w(1'b0, 8'h05, 2, 1'b1, 1'b0, 1'b0);
        chk("short_line", 32'(ERR_LINE), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_errs", 32'({ERR_LINE, ERR_FRAME, ERR_OVERRUN}), 32'd0);

        // long line: next line starts at index 4, 5th pixel dropped
        for (int p = 0; p < HP; p++) pix_w(1'b0, 8'h05, HP + p, 1'b0, 1'b0, 1'b0);
        chk("long_pre", 32'(ERR_LINE), 32'd0);
        pix_n(1'b1);
        chk("long_line", 32'(ERR_LINE), 32'd1);

        // frame ends after two lines
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("short_frame", 32'(ERR_FRAME), 32'd1);
        chk("sf_ready", 32'(FRAME_READY), 32'd1);
        chk("sf_rbank", 32'(READ_BANK), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ack2_ready", 32'(FRAME_READY), 32'd0);

        // next frame restarts at index 0 of the unchanged write bank
        run_frame(1'b0, 8'h06, 1'b0);
        chk("f6_rbank", 32'(READ_BANK), 32'd0);
        chk("f6_ready", 32'(FRAME_READY), 32'd1);

        // ack coincident with good frame end
        run_frame(1'b1, 8'h07, 1'b1);
        chk("f7_ovr", 32'(ERR_OVERRUN), 32'd0);
        chk("f7_rbank", 32'(READ_BANK), 32'd1);
        chk("f7_ready", 32'(FRAME_READY), 32'd1);

        // reset mid-line
        pix_w(1'b0, 8'h08, 0, 1'b0, 1'b0, 1'b0);
        pix_w(1'b0, 8'h08, 1, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        #1;
        chk("mr_we", 32'(MEM_WE), 32'd0);
        chk("mr_addr", 32'(MEM_ADDR), 32'd0);
        chk("mr_ready", 32'(FRAME_READY), 32'd0);
        chk("mr_rbank", 32'(READ_BANK), 32'd0);
        chk("mr_errs", 32'({ERR_LINE, ERR_FRAME, ERR_OVERRUN}), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle();
        pix_n(1'b0);
        pix_n(1'b1);
        pix_n(1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 8'h09, 1'b0);
        chk("f9_rbank", 32'(READ_BANK), 32'd0);
        chk("f9_ready", 32'(FRAME_READY), 32'd1);

        // drop ENABLE mid-frame
        for (int p = 0; p < HP; p++) pix_w(1'b1, 8'h0a, p, p == HP-1, 1'b0, 1'b0);
        pix_w(1'b1, 8'h0a, HP, 1'b0, 1'b0, 1'b0);
        ENABLE = 1'b0;
        idle();
        chk("dis_ready", 32'(FRAME_READY), 32'd1);
        chk("dis_rbank", 32'(READ_BANK), 32'd0);
        ENABLE = 1'b1;
        idle();
        pix_n(1'b0);
        pix_n(1'b1);
        pix_n(1'b0);
        chk("armed_errs", 32'({ERR_LINE, ERR_FRAME, ERR_OVERRUN}), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(1'b1, 8'h0b, 1'b0);
        chk("f11_rbank", 32'(READ_BANK), 32'd1);
        chk("f11_ready", 32'(FRAME_READY), 32'd1);
        chk("f11_errs", 32'({ERR_LINE, ERR_FRAME, ERR_OVERRUN}), 32'd0);
        idle();
        chk("tail_we", 32'(MEM_WE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
